// File: rtl/tsu_pkg.sv
// Shared types and constants for the timestamp-unit queue drain controller.
package tsu_pkg;

  localparam int TSU_QW    = 92;
  localparam int TSU_CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD,
    FLUSH
  } tsu_state_e;

endpackage

// File: rtl/tsu_rr_arb2.sv
// Two-way round-robin pick: with both requesting, the side not served last wins.
module tsu_rr_arb2
  import tsu_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/tsu_drain_ctrl.sv
// Drains two timestamp queues one entry at a time into a valid/ready consumer.
// Optional per-queue drained-entry counters are built when TSU_DRAIN_CNT_EN is defined.
module tsu_drain_ctrl
  import tsu_pkg::*;
#(
  parameter int QW        = TSU_QW,
  parameter int RD_LAT    = 1,
  parameter int FLUSH_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           q0_rd_stat,
  input  logic [7:0]           q1_rd_stat,
  input  logic [QW-1:0]        q0_rd_data,
  input  logic [QW-1:0]        q1_rd_data,
  output logic                 q0_rd_en,
  output logic                 q1_rd_en,
  output logic                 q_rst,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [QW-1:0]        out_data,
  output logic                 out_src,
  output logic [TSU_CNT_W-1:0] cnt0,
  output logic [TSU_CNT_W-1:0] cnt1
);

  localparam logic [1:0] LAT_LOAD   = 2'(RD_LAT - 1);
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_LEN - 1);

  tsu_state_e state, state_nxt;
  logic       sel;
  logic       last;
  logic [1:0] lat_cnt;
  logic [3:0] fl_cnt;
  logic [1:0] req;
  logic [1:0] grant;
  logic       cap;
  logic       hs;
  logic       stat_unused;

  // Only the used-word count matters; the remaining status bits are ignored.
  assign req         = {|q1_rd_stat[2:0], |q0_rd_stat[2:0]};
  assign stat_unused = ^{q0_rd_stat[7:3], q1_rd_stat[7:3]};

  tsu_rr_arb2 u_arb (
    .req   (req),
    .last  (last),
    .grant (grant)
  );

  assign cap = (state == WAIT) && (lat_cnt == '0) && !flush;
  assign hs  = (state == HOLD) && out_ready && !flush;

  always_comb begin
    state_nxt = state;
    q0_rd_en  = 1'b0;
    q1_rd_en  = 1'b0;
    q_rst     = 1'b0;
    case (state)
      IDLE:    if (|grant) state_nxt = ISSUE;
      ISSUE: begin
        state_nxt = WAIT;
        q0_rd_en  = !sel && !rst;
        q1_rd_en  = sel && !rst;
      end
      WAIT:    if (lat_cnt == '0) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      FLUSH: begin
        q_rst = 1'b1;
        if (fl_cnt == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A flush overrides every transition, including a same-cycle handshake.
    if (flush) state_nxt = FLUSH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= 1'b0;
      last      <= 1'b1;
      lat_cnt   <= '0;
      fl_cnt    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && |grant) sel <= grant[1];
      if (state == ISSUE)          lat_cnt <= LAT_LOAD;
      else if (lat_cnt != '0)      lat_cnt <= lat_cnt - 2'd1;
      if (flush)                   fl_cnt <= FLUSH_LOAD;
      else if (fl_cnt != '0)       fl_cnt <= fl_cnt - 4'd1;
      if (flush || hs)             out_valid <= 1'b0;
      else if (cap)                out_valid <= 1'b1;
      if (cap) begin
        out_data <= sel ? q1_rd_data : q0_rd_data;
        out_src  <= sel;
      end
      if (hs) last <= sel;
    end
  end

`ifdef TSU_DRAIN_CNT_EN
  function automatic logic [TSU_CNT_W-1:0] sat_inc(input logic [TSU_CNT_W-1:0] v);
    return (v == '1) ? v : v + TSU_CNT_W'(1);
  endfunction

  logic [TSU_CNT_W-1:0] cnt0_r, cnt1_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_r <= '0;
      cnt1_r <= '0;
    end else if (hs) begin
      if (sel) cnt1_r <= sat_inc(cnt1_r);
      else     cnt0_r <= sat_inc(cnt0_r);
    end
  end

  assign cnt0 = cnt0_r;
  assign cnt1 = cnt1_r;
`else
  assign cnt0 = '0;
  assign cnt1 = '0;
`endif

endmodule

// File: tb/tb_tsu_drain_ctrl.sv
// Bench for tsu_drain_ctrl: emulated queues, schedule-based reference model, directed and random phases.
module tb_tsu_drain_ctrl;
  import tsu_pkg::*;

  localparam int QW        = TSU_QW;
  localparam int RD_LAT    = 1;
  localparam int FLUSH_LEN = 4;
`ifdef TSU_DRAIN_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef logic [QW-1:0] word_t;

  logic        clk = 1'b0;
  logic        rst, flush, out_ready;
  logic [7:0]  q0_rd_stat, q1_rd_stat;
  word_t       q0_rd_data, q1_rd_data;
  logic        q0_rd_en, q1_rd_en, q_rst, out_valid, out_src;
  word_t       out_data;
  logic [15:0] cnt0, cnt1;

  always #5 clk = ~clk;

  tsu_drain_ctrl #(.QW(QW), .RD_LAT(RD_LAT), .FLUSH_LEN(FLUSH_LEN)) dut (
    .clk(clk), .rst(rst),
    .q0_rd_stat(q0_rd_stat), .q1_rd_stat(q1_rd_stat),
    .q0_rd_data(q0_rd_data), .q1_rd_data(q1_rd_data),
    .q0_rd_en(q0_rd_en), .q1_rd_en(q1_rd_en), .q_rst(q_rst),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_src(out_src), .cnt0(cnt0), .cnt1(cnt1)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // queue emulation
  word_t fifo0[$];
  word_t fifo1[$];
  word_t pipe_d[2][4];
  bit    pipe_v[2][4];

  // stimulus controls
  bit drv_rst = 1'b1, drv_flush = 1'b0, drv_ready = 1'b1, rand_mode = 1'b0;
  int stall_left = 0;

  // reference model: absolute cycle schedule of the current transaction
  bit    m_known = 1'b0, m_sample, m_hold, m_sel, m_src, m_last;
  int    m_rd_cyc = -1, m_cap_cyc = -1, m_flush_end = -1;
  word_t m_data;
  int    m_cnt[2];

  function automatic word_t rand_word();
    logic [95:0] w;
    w = {$urandom(), $urandom(), $urandom()};
    return w[QW-1:0];
  endfunction

  task automatic chk(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic check_and_model();
    bit e0, e1;
    word_t v;
    int k;
    if (m_known) begin
      chk("q0_rd_en", word_t'(q0_rd_en), word_t'(m_rd_cyc == cyc && m_sel == 1'b0 && !rst));
      chk("q1_rd_en", word_t'(q1_rd_en), word_t'(m_rd_cyc == cyc && m_sel == 1'b1 && !rst));
      chk("q_rst", word_t'(q_rst), word_t'(cyc <= m_flush_end));
      chk("out_valid", word_t'(out_valid), word_t'(m_hold));
      if (m_hold) begin
        chk("out_data", out_data, m_data);
        chk("out_src", word_t'(out_src), word_t'(m_src));
      end
      chk("cnt0", word_t'(cnt0), word_t'(m_cnt[0]));
      chk("cnt1", word_t'(cnt1), word_t'(m_cnt[1]));
    end
    if (rst) begin
      m_known = 1'b1; m_sample = 1'b1; m_hold = 1'b0; m_last = 1'b1; m_sel = 1'b0;
      m_rd_cyc = -1; m_cap_cyc = -1; m_flush_end = -1;
      m_cnt[0] = 0; m_cnt[1] = 0;
    end else if (m_known) begin
      if (flush) begin
        m_sample = 1'b0; m_hold = 1'b0; m_rd_cyc = -1; m_cap_cyc = -1;
        m_flush_end = cyc + FLUSH_LEN;
      end else begin
        if (m_rd_cyc == cyc) begin
          m_src = m_sel;
          if (m_sel) m_data = (fifo1.size() > 0) ? fifo1[0] : '0;
          else       m_data = (fifo0.size() > 0) ? fifo0[0] : '0;
        end
        if (m_hold && out_ready) begin
          m_hold = 1'b0; m_last = m_src; m_sample = 1'b1;
          if (CNT_EN && m_cnt[m_src] != 32'hFFFF) m_cnt[m_src]++;
        end else if (m_cap_cyc == cyc + 1) begin
          m_hold = 1'b1;
        end else if (m_flush_end == cyc) begin
          m_sample = 1'b1;
        end else if (m_sample) begin
          e0 = (q0_rd_stat[2:0] != 3'd0);
          e1 = (q1_rd_stat[2:0] != 3'd0);
          if (e0 || e1) begin
            m_sel = (e0 && e1) ? !m_last : e1;
            m_rd_cyc = cyc + 1; m_cap_cyc = cyc + 2 + RD_LAT; m_sample = 1'b0;
          end
        end
      end
    end
    // queue side reacts to the controller's strobes
    k = (cyc + RD_LAT) % 4;
    if (q0_rd_en) begin
      v = (fifo0.size() > 0) ? fifo0.pop_front() : '0;
      pipe_d[0][k] = v; pipe_v[0][k] = 1'b1;
    end
    if (q1_rd_en) begin
      v = (fifo1.size() > 0) ? fifo1.pop_front() : '0;
      pipe_d[1][k] = v; pipe_v[1][k] = 1'b1;
    end
    if (q_rst) begin
      fifo0.delete(); fifo1.delete();
    end else if (rand_mode) begin
      if (fifo0.size() < 7 && $urandom_range(0, 99) < 30) fifo0.push_back(rand_word());
      if (fifo1.size() < 7 && $urandom_range(0, 99) < 30) fifo1.push_back(rand_word());
    end
  endtask

  task automatic cycle();
    int k;
    @(posedge clk);
    #1;
    cyc++;
    k = cyc % 4;
    q0_rd_data = pipe_v[0][k] ? pipe_d[0][k] : rand_word();
    q1_rd_data = pipe_v[1][k] ? pipe_d[1][k] : rand_word();
    pipe_v[0][k] = 1'b0; pipe_v[1][k] = 1'b0;
    q0_rd_stat = {5'($urandom_range(0, 31)), 3'(fifo0.size())};
    q1_rd_stat = {5'($urandom_range(0, 31)), 3'(fifo1.size())};
    if (rand_mode) begin
      drv_rst   = ($urandom_range(0, 399) == 0);
      drv_flush = ($urandom_range(0, 59) == 0);
      if (stall_left > 0) begin
        drv_ready = 1'b0; stall_left--;
      end else if ($urandom_range(0, 19) == 0) begin
        drv_ready = 1'b0; stall_left = $urandom_range(10, 15);
      end else begin
        drv_ready = ($urandom_range(0, 3) != 0);
      end
    end
    rst = drv_rst; flush = drv_flush; out_ready = drv_ready;
    @(negedge clk);
    check_and_model();
  endtask

  task automatic do_reset();
    fifo0.delete(); fifo1.delete();
    drv_rst = 1'b1; drv_flush = 1'b0;
    cycle();
    drv_rst = 1'b0;
    cycle();
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_valid && n < 20) begin
      cycle(); n++;
    end
    chk(name, word_t'(out_valid), word_t'(1));
  endtask

  initial begin
    word_t d0, held;
    logic  srcs[4];
    int    nhs, both, rdc, unstable, qr, found;

    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    q0_rd_stat = '0; q1_rd_stat = '0; q0_rd_data = '0; q1_rd_data = '0;
    repeat (2) cycle();
    do_reset();

    // state straight after reset
    chk("rst_q0_rd_en", word_t'(q0_rd_en), '0);
    chk("rst_q1_rd_en", word_t'(q1_rd_en), '0);
    chk("rst_q_rst", word_t'(q_rst), '0);
    chk("rst_out_valid", word_t'(out_valid), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_src", word_t'(out_src), '0);
    chk("rst_cnt0", word_t'(cnt0), '0);
    chk("rst_cnt1", word_t'(cnt1), '0);

    // single q0 entry: rd_en at t+1, out_valid at t+3
    d0 = rand_word();
    fifo0.push_back(d0);
    drv_ready = 1'b1;
    cycle();
    chk("t0_no_rd_en", word_t'(q0_rd_en), '0);
    cycle();
    chk("t1_q0_rd_en", word_t'(q0_rd_en), word_t'(1));
    chk("t1_q1_rd_en", word_t'(q1_rd_en), '0);
    cycle();
    chk("t2_out_valid", word_t'(out_valid), '0);
    cycle();
    chk("t3_out_valid", word_t'(out_valid), word_t'(1));
    chk("t3_out_src", word_t'(out_src), '0);
    chk("t3_out_data", out_data, d0);
    cycle();
    chk("t4_cnt0", word_t'(cnt0), CNT_EN ? word_t'(1) : '0);

    // both queues loaded: strict alternation starting with q0
    do_reset();
    repeat (3) begin
      fifo0.push_back(rand_word()); fifo1.push_back(rand_word());
    end
    drv_ready = 1'b1; nhs = 0; both = 0;
    for (int i = 0; i < 4; i++) srcs[i] = 1'bx;
    for (int i = 0; i < 80 && nhs < 4; i++) begin
      cycle();
      if (q0_rd_en && q1_rd_en) both++;
      if (out_valid && out_ready) begin
        srcs[nhs] = out_src; nhs++;
      end
    end
    chk("alt_handshakes", word_t'(nhs), word_t'(4));
    for (int i = 0; i < 4; i++) chk("alt_src", word_t'(srcs[i]), word_t'(i % 2));
    chk("alt_both_rd_en", word_t'(both), '0);

    // consumer stall in HOLD
    do_reset();
    fifo0.push_back(rand_word()); fifo0.push_back(rand_word());
    drv_ready = 1'b0;
    wait_valid("stall_valid");
    held = out_data; rdc = 0; unstable = 0;
    repeat (10) begin
      cycle();
      if (q0_rd_en || q1_rd_en) rdc++;
      if (!out_valid || out_data !== held) unstable++;
    end
    chk("stall_rd_en", word_t'(rdc), '0);
    chk("stall_stable", word_t'(unstable), '0);
    drv_ready = 1'b1;
    cycle();
    drv_ready = 1'b0;
    cycle();
    chk("stall_cnt0", word_t'(cnt0), CNT_EN ? word_t'(1) : '0);

    // flush colliding with a handshake
    do_reset();
    fifo0.push_back(rand_word()); fifo0.push_back(rand_word());
    drv_ready = 1'b0;
    wait_valid("flush_valid");
    drv_ready = 1'b1; drv_flush = 1'b1;
    cycle();
    drv_flush = 1'b0; qr = 0; rdc = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (i == 0) chk("flush_valid_drop", word_t'(out_valid), '0);
      if (q_rst) qr++;
      if (q0_rd_en || q1_rd_en) rdc++;
    end
    chk("flush_qrst_len", word_t'(qr), word_t'(FLUSH_LEN));
    chk("flush_rd_en", word_t'(rdc), '0);
    chk("flush_cnt0", word_t'(cnt0), '0);
    fifo0.push_back(rand_word());
    found = 0;
    for (int i = 0; i < 6 && found == 0; i++) begin
      cycle();
      if (q0_rd_en) found = 1;
    end
    chk("flush_then_idle", word_t'(found), word_t'(1));

    // counter saturation
    do_reset();
`ifdef TSU_DRAIN_CNT_EN
    force dut.cnt0_r = 16'hFFFE;
    #1;
    release dut.cnt0_r;
    m_cnt[0] = 32'hFFFE;
`endif
    repeat (3) fifo0.push_back(rand_word());
    drv_ready = 1'b1; nhs = 0;
    for (int i = 0; i < 60 && nhs < 3; i++) begin
      cycle();
      if (out_valid && out_ready) nhs++;
    end
    chk("sat_handshakes", word_t'(nhs), word_t'(3));
    cycle();
    chk("sat_cnt0", word_t'(cnt0), CNT_EN ? word_t'(16'hFFFF) : '0);

    // randomized traffic against the model
    do_reset();
    rand_mode = 1'b1;
    repeat (4000) cycle();
    rand_mode = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
